mod_inverse: RTL and testbench
==============================

# mod_inverse

Sequential modular multiplicative inverse for the Keychain RSA datapath. Given a public exponent `e` and a modulus `phi`, the block computes `d = e^-1 mod phi` with the extended Euclidean algorithm. It supplies the private exponent that the modular-exponentiation block consumes for decryption. It uses the same `ready_in`/`busy_out`/`valid_out` start–done handshake as the rest of the crypto blocks.

## Interface
- `WIDTH`, default 8: operand and result width in bits.
- `clk_in`  input  1  system clock; all state changes on the rising edge.
- `rst_in`  input  1  reset; asynchronous, active-high.
- `ready_in`  input  1  start request; sampled only while `busy_out` is low.
- `value_in`  input  WIDTH  operand `e` (unsigned), captured on start.
- `modulus_in`  input  WIDTH  modulus `phi` (unsigned), captured on start.
- `inverse_out`  output  WIDTH  `d` in `[0, phi-1]`; 0 when no inverse exists.
- `exists_out`  output  1  high when `gcd(e, phi) = 1` and `phi >= 2`.
- `busy_out`  output  1  high from the capture edge until the FINISH edge.
- `valid_out`  output  1  one-cycle pulse in the first cycle after `busy_out` falls.

## Operation
- Registers:
  - `r0`, `r1`: unsigned, WIDTH bits.
  - `t0`, `t1`: signed, WIDTH+2 bits.
  - `q`: WIDTH bits.
  - Division shift counter.
  - `phi` copy.
- Start occurs when `ready_in && !busy_out`. It loads:
  - `r0 = modulus_in`, `r1 = value_in`.
  - `t0 = 0`, `t1 = 1`.
  - `busy_out <= 1`, next state CHECK.
- `ready_in` while busy is ignored and does not queue a request. Inputs may change after the capture edge.
- IDLE: wait for start.
- CHECK (1 cycle):
  - If `phi < 2`, go to FINISH with no inverse.
  - Else if `r1 == 0`, go to FINISH.
  - Else go to DIVIDE.
- DIVIDE (exactly WIDTH cycles): restoring division `r0 / r1`, one quotient bit per cycle, MSB first. It produces `q` and remainder `rem`. Division by zero is unreachable because CHECK guards it.
- UPDATE (1 cycle):
  - `(r0, r1) <= (r1, rem)`.
  - `(t0, t1) <= (t1, t0 - q*t1)`, computed at WIDTH+2 signed width; the product is truncated to that width.
  - Next state CHECK.
- If `e >= phi`, the first iteration yields `q = 0` and acts as a swap. No special case is needed.
- FINISH (1 cycle):
  - If `r0 == 1` and `phi >= 2`: `exists_out <= 1` and `inverse_out <= (t0 < 0) ? t0 + phi : t0`, truncated to WIDTH.
  - Else: `exists_out <= 0`, `inverse_out <= 0`.
  - `busy_out <= 0`, `valid_out <= 1`, next state IDLE.
- `valid_out` is cleared on the following edge.
- `inverse_out` and `exists_out` hold until the next FINISH. They are not cleared on start.

## Timing
- Reset values: `inverse_out = 0`, `exists_out = 0`, `busy_out = 0`, `valid_out = 0`, state IDLE, all datapath registers 0.
- Reset asserted mid-operation aborts immediately to IDLE. No `valid_out` is produced.
- With `k` Euclid iterations (DIVIDE + UPDATE passes), `busy_out` is high for exactly `k*(WIDTH+2) + 2` cycles.
- `valid_out` follows `busy_out` falling by one cycle.
- A new start is accepted in the same cycle `valid_out` is high, because `busy_out` is low then.
- Worst-case `k` is at most `2*WIDTH`.
- `|t|` stays at or below `phi`. WIDTH+2 signed width is sufficient and overflow-free.

## Structure
- Shared package `keychain_pkg`:
  - State enum `minv_state_t` with IDLE, CHECK, DIVIDE, UPDATE, FINISH.
  - Default `WIDTH` constant, shared with the exponent block.
- One sub-module, `restoring_divider`:
  - Start/done handshake.
  - WIDTH-cycle unsigned divide.
  - Outputs quotient and remainder.
  - Reusable by the modulus path.
- The multiply in UPDATE is a single inferred WIDTH × (WIDTH+2) multiplier. There is no separate module.

## Test plan
- `e=7`, `phi=160` → `inverse_out=23`, `exists_out=1`. `k=3`, so `busy_out` is high 32 cycles, then a single `valid_out` pulse.
- `e=3`, `phi=7` → 5, exists. `e=10`, `phi=7` (`e >= phi`) → 5, exists. Check that `busy_out` width matches `k*10+2` for each.
- `e=6`, `phi=9` → `exists_out=0`, `inverse_out=0`. `e=0`, `phi=9` → no inverse, `busy_out` 2 cycles.
- `phi=1` and `phi=0` with any `e` → `exists_out=0`, `inverse_out=0`, `busy_out` 2 cycles, `valid_out` pulse.
- Pulse `ready_in` mid-operation with new operands → ignored, result unchanged. Assert `rst_in` mid-DIVIDE → all outputs 0 at once, no `valid_out`. A subsequent start with `e=7`, `phi=160` → 23.
- Random sweep over all `e`, `phi` in `[0, 255]`: if `exists_out=1` then `(e*inverse_out) mod phi == 1`; `exists_out` equals `(gcd(e, phi) == 1 && phi >= 2)`.

Source files
------------

// File: rtl/keychain_pkg.sv
// Shared definitions for the Keychain RSA datapath blocks.
// Holds the default operand width and the inverse-unit state encoding.
package keychain_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIVIDE,
      UPDATE,
      FINISH
   } minv_state_t;

endpackage

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles.
// done_in_cycle is high during the cycle whose edge retires the final bit.
module restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic             done_out
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   trial;
   logic             fits;

   // The quotient register doubles as the dividend shift register.
   always_comb begin
      partial = {remainder_out, quotient_out[WIDTH-1]};
      fits    = (partial >= {1'b0, divisor});
      trial   = partial - {1'b0, divisor};
   end

   assign done_out = (count == CW'(1));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         count         <= '0;
         divisor       <= '0;
         quotient_out  <= '0;
         remainder_out <= '0;
      end else if (start_in) begin
         count         <= CW'(WIDTH);
         divisor       <= divisor_in;
         quotient_out  <= dividend_in;
         remainder_out <= '0;
      end else if (count != '0) begin
         count         <= count - CW'(1);
         quotient_out  <= {quotient_out[WIDTH-2:0], fits};
         remainder_out <= fits ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mod_inverse.sv
// Sequential modular inverse d = e^-1 mod phi via the extended Euclidean algorithm.
// Each Euclid iteration costs CHECK + WIDTH divide cycles + UPDATE.
module mod_inverse
   import keychain_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             ready_in,
   input  logic [WIDTH-1:0] value_in,
   input  logic [WIDTH-1:0] modulus_in,
   output logic [WIDTH-1:0] inverse_out,
   output logic             exists_out,
   output logic             busy_out,
   output logic             valid_out
);

   minv_state_t state;
   minv_state_t state_next;

   logic [WIDTH-1:0]        r0;
   logic [WIDTH-1:0]        r1;
   logic [WIDTH-1:0]        phi;
   logic signed [WIDTH+1:0] t0;
   logic signed [WIDTH+1:0] t1;
   logic signed [WIDTH+1:0] q_ext;
   logic signed [WIDTH+1:0] product;
   logic [WIDTH-1:0]        q;
   logic [WIDTH-1:0]        rem;
   logic [WIDTH-1:0]        inverse_next;
   logic                    div_start;
   logic                    div_done;
   logic                    start;
   logic                    phi_ok;

   assign start  = ready_in && !busy_out;
   assign phi_ok = (phi >= WIDTH'(2));

   restoring_divider #(.WIDTH(WIDTH)) divider (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (div_start),
      .dividend_in   (r0),
      .divisor_in    (r1),
      .quotient_out  (q),
      .remainder_out (rem),
      .done_out      (div_done)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      div_start  = 1'b0;
      case (state)
         IDLE:    if (start) state_next = CHECK;
         CHECK: begin
            if (!phi_ok || r1 == '0) begin
               state_next = FINISH;
            end else begin
               state_next = DIVIDE;
               div_start  = 1'b1;
            end
         end
         DIVIDE:  if (div_done) state_next = UPDATE;
         UPDATE:  state_next = CHECK;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Truncation to WIDTH bits makes "add phi when negative" exact modulo 2^WIDTH.
   always_comb begin
      q_ext        = signed'({2'b00, q});
      product      = q_ext * t1;
      inverse_next = t0[WIDTH-1:0] + (t0[WIDTH+1] ? phi : '0);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r0          <= '0;
         r1          <= '0;
         phi         <= '0;
         t0          <= '0;
         t1          <= '0;
         inverse_out <= '0;
         exists_out  <= 1'b0;
         busy_out    <= 1'b0;
         valid_out   <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  r0       <= modulus_in;
                  r1       <= value_in;
                  phi      <= modulus_in;
                  t0       <= '0;
                  t1       <= (WIDTH+2)'(1);
                  busy_out <= 1'b1;
               end
            end
            UPDATE: begin
               r0 <= r1;
               r1 <= rem;
               t0 <= t1;
               t1 <= t0 - product;
            end
            FINISH: begin
               if (r0 == WIDTH'(1) && phi_ok) begin
                  exists_out  <= 1'b1;
                  inverse_out <= inverse_next;
               end else begin
                  exists_out  <= 1'b0;
                  inverse_out <= '0;
               end
               busy_out  <= 1'b0;
               valid_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_inverse.sv
// Directed and randomized checks for mod_inverse at WIDTH = 8.
module tb_mod_inverse;

   localparam int W     = 8;
   localparam int LIMIT = 400;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b0;
   logic         ready_in = 1'b0;
   logic [W-1:0] value_in = '0;
   logic [W-1:0] modulus_in = '0;
   logic [W-1:0] inverse_out;
   logic         exists_out;
   logic         busy_out;
   logic         valid_out;

   int vectors = 0;
   int miscompares = 0;

   mod_inverse #(.WIDTH(W)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .ready_in    (ready_in),
      .value_in    (value_in),
      .modulus_in  (modulus_in),
      .inverse_out (inverse_out),
      .exists_out  (exists_out),
      .busy_out    (busy_out),
      .valid_out   (valid_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic int gcd_of(input int a_in, input int b_in);
      int a = a_in;
      int b = b_in;
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int iterations(input int e, input int phi);
      int a = phi;
      int b = e;
      int t;
      int k = 0;
      if (phi < 2) return 0;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
         k++;
      end
      return k;
   endfunction

   function automatic int brute_inverse(input int e, input int phi);
      for (int d = 0; d < phi; d++)
         if ((e * d) % phi == 1) return d;
      return 0;
   endfunction

   // Start one operation and report what was seen when busy_out dropped.
   task automatic run_op(input int e, input int phi, output logic [W-1:0] inv,
                         output logic ex, output int cycles, output logic v_fall,
                         output logic v_after);
      @(negedge clk_in);
      value_in   = W'(e);
      modulus_in = W'(phi);
      ready_in   = 1'b1;
      @(negedge clk_in);
      ready_in   = 1'b0;
      value_in   = W'($urandom);
      modulus_in = W'($urandom);
      cycles = 0;
      while (busy_out && cycles < LIMIT) begin
         cycles++;
         @(negedge clk_in);
      end
      v_fall = valid_out;
      inv    = inverse_out;
      ex     = exists_out;
      @(negedge clk_in);
      v_after = valid_out;
   endtask

   task automatic test_reset;
      rst_in = 1'b1;
      @(negedge clk_in);
      vectors++;
      if ({inverse_out, exists_out, busy_out, valid_out} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs got inv=%0d ex=%b busy=%b valid=%b want all 0",
                  inverse_out, exists_out, busy_out, valid_out);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_directed;
      int te[7]   = '{7, 3, 10, 6, 0, 5, 5};
      int tp[7]   = '{160, 7, 7, 9, 9, 1, 0};
      int ti[7]   = '{23, 5, 5, 0, 0, 0, 0};
      int tx[7]   = '{1, 1, 1, 0, 0, 0, 0};
      int tk[7]   = '{3, 2, 4, 2, 0, 0, 0};
      logic [W-1:0] inv;
      logic ex, vf, va;
      int cycles;
      for (int i = 0; i < 7; i++) begin
         run_op(te[i], tp[i], inv, ex, cycles, vf, va);
         vectors++;
         if (inv !== W'(ti[i]) || ex !== tx[i][0]) begin
            miscompares++;
            $display("[TB] FAIL directed_result e=%0d phi=%0d got inv=%0d ex=%b want inv=%0d ex=%0d",
                     te[i], tp[i], inv, ex, ti[i], tx[i]);
         end
         vectors++;
         if (cycles != tk[i] * (W + 2) + 2) begin
            miscompares++;
            $display("[TB] FAIL directed_busy_width e=%0d phi=%0d got %0d want %0d",
                     te[i], tp[i], cycles, tk[i] * (W + 2) + 2);
         end
         vectors++;
         if (vf !== 1'b1 || va !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL directed_valid_pulse e=%0d phi=%0d got %b%b want 10",
                     te[i], tp[i], vf, va);
         end
      end
   endtask

   task automatic test_ignore_ready;
      int cycles;
      // Previous directed op (phi=0) left inverse_out at 0; seed a known value first.
      logic [W-1:0] inv;
      logic ex, vf, va;
      run_op(3, 7, inv, ex, cycles, vf, va);
      @(negedge clk_in);
      value_in = 8'd7; modulus_in = 8'd160; ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      cycles = 1;
      repeat (4) begin
         @(negedge clk_in);
         cycles++;
      end
      vectors++;
      if (busy_out !== 1'b1 || inverse_out !== 8'd5 || exists_out !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL hold_during_busy got busy=%b inv=%0d ex=%b want 1 5 1",
                  busy_out, inverse_out, exists_out);
      end
      value_in = 8'd3; modulus_in = 8'd7; ready_in = 1'b1;
      @(negedge clk_in);
      cycles++;
      ready_in = 1'b0;
      while (busy_out && cycles < LIMIT) begin
         @(negedge clk_in);
         if (busy_out) cycles++;
      end
      vectors++;
      if (inverse_out !== 8'd23 || exists_out !== 1'b1 || cycles != 32) begin
         miscompares++;
         $display("[TB] FAIL ignore_ready got inv=%0d ex=%b busy=%0d want 23 1 32",
                  inverse_out, exists_out, cycles);
      end
      @(negedge clk_in);
   endtask

   task automatic test_reset_abort;
      logic seen_valid = 1'b0;
      logic [W-1:0] inv;
      logic ex, vf, va;
      int cycles;
      @(negedge clk_in);
      value_in = 8'd7; modulus_in = 8'd160; ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      repeat (4) @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      vectors++;
      if ({inverse_out, exists_out, busy_out, valid_out} !== '0) begin
         miscompares++;
         $display("[TB] FAIL abort_outputs got inv=%0d ex=%b busy=%b valid=%b want all 0",
                  inverse_out, exists_out, busy_out, valid_out);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (40) begin
         @(negedge clk_in);
         if (valid_out || busy_out) seen_valid = 1'b1;
      end
      vectors++;
      if (seen_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_valid got activity=%b want 0", seen_valid);
      end
      run_op(7, 160, inv, ex, cycles, vf, va);
      vectors++;
      if (inv !== 8'd23 || ex !== 1'b1 || cycles != 32) begin
         miscompares++;
         $display("[TB] FAIL after_abort got inv=%0d ex=%b busy=%0d want 23 1 32",
                  inv, ex, cycles);
      end
   endtask

   task automatic test_back_to_back;
      int cycles = 0;
      @(negedge clk_in);
      value_in = 8'd3; modulus_in = 8'd7; ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      while (!valid_out && cycles < LIMIT) begin
         @(negedge clk_in);
         cycles++;
      end
      value_in = 8'd7; modulus_in = 8'd160; ready_in = 1'b1;
      @(negedge clk_in);
      ready_in = 1'b0;
      vectors++;
      if (busy_out !== 1'b1 || inverse_out !== 8'd5) begin
         miscompares++;
         $display("[TB] FAIL back_to_back_accept got busy=%b inv=%0d want 1 5",
                  busy_out, inverse_out);
      end
      cycles = 0;
      while (busy_out && cycles < LIMIT) begin
         cycles++;
         @(negedge clk_in);
      end
      vectors++;
      if (inverse_out !== 8'd23 || valid_out !== 1'b1 || cycles != 32) begin
         miscompares++;
         $display("[TB] FAIL back_to_back_result got inv=%0d valid=%b busy=%0d want 23 1 32",
                  inverse_out, valid_out, cycles);
      end
   endtask

   task automatic test_sweep;
      logic [W-1:0] inv;
      logic ex, vf, va;
      int cycles, e, phi, want_inv, want_k;
      logic want_ex;
      for (int n = 0; n < 130; n++) begin
         case (n)
            0:       begin e = 1;   phi = 2;   end
            1:       begin e = 255; phi = 254; end
            2:       begin e = 254; phi = 255; end
            3:       begin e = 144; phi = 233; end
            default: begin e = $urandom_range(0, 255); phi = $urandom_range(0, 255); end
         endcase
         want_ex  = (phi >= 2) && (gcd_of(e, phi) == 1);
         want_inv = want_ex ? brute_inverse(e, phi) : 0;
         want_k   = iterations(e, phi);
         run_op(e, phi, inv, ex, cycles, vf, va);
         vectors++;
         if (ex !== want_ex || inv !== W'(want_inv)) begin
            miscompares++;
            $display("[TB] FAIL sweep_result e=%0d phi=%0d got inv=%0d ex=%b want inv=%0d ex=%b",
                     e, phi, inv, ex, want_inv, want_ex);
         end
         vectors++;
         if (cycles != want_k * (W + 2) + 2 || vf !== 1'b1 || va !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sweep_timing e=%0d phi=%0d got busy=%0d pulse=%b%b want busy=%0d pulse=10",
                     e, phi, cycles, vf, va, want_k * (W + 2) + 2);
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_ignore_ready;
      test_reset_abort;
      test_back_to_back;
      test_sweep;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
